// File: rtl/ifu_pkg.sv
//============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               Holds the fetch FSM state encoding, the PC increment and the
//               default address/instruction geometry of the core.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package ifu_pkg;

    // Default core geometry; the ifu exposes these as overridable parameters.
    localparam int                 CFG_ADDR_WIDTH = 32;
    localparam int                 CFG_INST_WIDTH = 32;
    localparam logic [31:0]        CFG_ADDR_INIT  = 32'h8000_0000;
    localparam logic [31:0]        CFG_DATA_ZERO  = 32'h0000_0000;

    // Byte distance between consecutive 32-bit instructions.
    localparam int                 PC_STEP        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_state_e;

endpackage : ifu_pkg

`default_nettype wire

// File: rtl/ifu_pc_reg.sv
//============================================================================
// Module      : ifu_pc_reg
// Description : Program counter register with its next-PC selection.
//               Priority: freeze > jump load > step (+PC_STEP) > hold.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               freeze         - hold PC regardless of other requests
//               jmp_load       - load jmp_pc (already checked for alignment)
//               jmp_pc         - redirect target
//               step           - advance to the next sequential instruction
//               pc             - current program counter
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = CFG_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = CFG_ADDR_INIT[ADDR_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  jmp_load,
    input  logic [ADDR_WIDTH-1:0] jmp_pc,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_next;

    // Sequential increment wraps naturally at 2^ADDR_WIDTH; the ROM decodes
    // out-of-range addresses itself.
    always_comb begin
        pc_next = pc;
        if (freeze) begin
            pc_next = pc;
        end else if (jmp_load) begin
            pc_next = jmp_pc;
        end else if (step) begin
            pc_next = pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_INIT;
        end else begin
            pc <= pc_next;
        end
    end

endmodule : ifu_pc_reg

`default_nettype wire

// File: rtl/ifu.sv
//============================================================================
// Module      : ifu
// Description : Instruction fetch stage. Drives the ROM combinational read
//               port from the PC, registers {pc, inst} into the IF/ID slot
//               and hands it to decode with a valid/ready handshake. Handles
//               jump redirect (with flush), misaligned-target trap and halt.
// Ports       : i_clk, i_rst_n          - clock, async active-low reset
//               i_jmp_en, i_jmp_pc      - redirect request / target
//               i_halt                  - stop fetching
//               i_idu_ready             - decode accepts the slot
//               o_rom_rd_en/addr, i_rom_rd_data - ROM read port
//               o_idu_valid/pc/inst     - IF/ID slot
//               o_excp_misalign         - sticky misaligned-target flag
//               o_halted                - fetch stage is halted
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ifu
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = CFG_ADDR_WIDTH,
    parameter int                    INST_WIDTH = CFG_INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = CFG_ADDR_INIT[ADDR_WIDTH-1:0]
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
    input  logic                  i_halt,
    input  logic                  i_idu_ready,
    output logic                  o_rom_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rom_rd_addr,
    input  logic [INST_WIDTH-1:0] i_rom_rd_data,
    output logic                  o_idu_valid,
    output logic [ADDR_WIDTH-1:0] o_idu_pc,
    output logic [INST_WIDTH-1:0] o_idu_inst,
    output logic                  o_excp_misalign,
    output logic                  o_halted
);

    ifu_state_e            state;
    ifu_state_e            state_next;
    logic [ADDR_WIDTH-1:0] pc;

    logic in_run;
    logic fire;
    logic jmp_ok;
    logic jmp_bad;
    logic fetch;

    // Per-edge decisions in RUN, ordered halt > jump > fetch.
    assign in_run  = (state == RUN);
    assign fire    = !o_idu_valid || i_idu_ready;
    assign jmp_ok  = in_run && !i_halt && i_jmp_en && (i_jmp_pc[1:0] == 2'b00);
    assign jmp_bad = in_run && !i_halt && i_jmp_en && (i_jmp_pc[1:0] != 2'b00);
    assign fetch   = in_run && !i_halt && !i_jmp_en && fire;

    ifu_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_INIT  (ADDR_INIT)
    ) u_pc_reg (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .freeze   (!in_run || i_halt || jmp_bad),
        .jmp_load (jmp_ok),
        .jmp_pc   (i_jmp_pc),
        .step     (fetch),
        .pc       (pc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        o_rom_rd_en   = 1'b0;
        o_halted      = 1'b0;
        o_rom_rd_addr = pc;
        unique case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                o_rom_rd_en = 1'b1;
                if (i_halt || jmp_bad) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // IF/ID slot. Outside of a fetch or a redirect the slot only drains:
    // that single rule covers IDLE, HALT, the halt edge and a stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_idu_valid <= 1'b0;
            o_idu_pc    <= ADDR_INIT;
            o_idu_inst  <= '0;
        end else if (jmp_ok || jmp_bad) begin
            o_idu_valid <= 1'b0;
        end else if (fetch) begin
            o_idu_valid <= 1'b1;
            o_idu_pc    <= pc;
            o_idu_inst  <= i_rom_rd_data;
        end else begin
            o_idu_valid <= o_idu_valid && !i_idu_ready;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_excp_misalign <= 1'b0;
        end else if (jmp_bad) begin
            o_excp_misalign <= 1'b1;
        end
    end

endmodule : ifu

`default_nettype wire

// File: tb/tb_ifu.sv
//============================================================================
// Module      : tb_ifu
// Description : Scoreboard bench for ifu. Stimulus pushes expected {pc,inst}
//               pairs; a negedge monitor pops one per accepted handshake.
//               The ROM holds word = (addr - 0x80000000) / 4.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ifu;

    localparam logic [31:0] INIT = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        jmp_en;
    logic [31:0] jmp_pc;
    logic        halt;
    logic        ready;
    logic        rom_rd_en;
    logic [31:0] rom_rd_addr;
    logic [31:0] rom_rd_data;
    logic        idu_valid;
    logic [31:0] idu_pc;
    logic [31:0] idu_inst;
    logic        excp_misalign;
    logic        halted;

    int tests;
    int fails;

    logic [63:0] exp_q[$];

    ifu #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .ADDR_INIT  (INIT)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_jmp_en        (jmp_en),
        .i_jmp_pc        (jmp_pc),
        .i_halt          (halt),
        .i_idu_ready     (ready),
        .o_rom_rd_en     (rom_rd_en),
        .o_rom_rd_addr   (rom_rd_addr),
        .i_rom_rd_data   (rom_rd_data),
        .o_idu_valid     (idu_valid),
        .o_idu_pc        (idu_pc),
        .o_idu_inst      (idu_inst),
        .o_excp_misalign (excp_misalign),
        .o_halted        (halted)
    );

    assign rom_rd_data = (rom_rd_addr - INIT) >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({pc, (pc - INIT) >> 2});
    endtask

    // Monitor: a slot with valid && ready at negedge is consumed at the next edge.
    always @(negedge clk) begin
        if (rst_n && idu_valid && ready) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got pc %h inst %h expected none", idu_pc, idu_inst);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", idu_pc, e[63:32]);
                check("sb_inst", idu_inst, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        jmp_en = 1'b0;
        jmp_pc = '0;
        halt   = 1'b0;
        ready  = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, idu_valid}, 32'd0);
        check("rst_pc", idu_pc, INIT);
        check("rst_inst", idu_inst, 32'd0);
        check("rst_rom_en", {31'd0, rom_rd_en}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_misalign", {31'd0, excp_misalign}, 32'd0);

        // 1: streaming with ready high
        rst_n = 1'b1;
        push(INIT);
        push(INIT + 32'h4);
        push(INIT + 32'h8);
        check("idle_rom_en", {31'd0, rom_rd_en}, 32'd0);
        tick();
        check("run_rom_en", {31'd0, rom_rd_en}, 32'd1);
        check("run_addr", rom_rd_addr, INIT);
        check("run_valid0", {31'd0, idu_valid}, 32'd0);
        tick();
        check("s1_pc0", idu_pc, INIT);
        tick();
        check("s1_pc1", idu_pc, INIT + 32'h4);
        tick();
        check("s1_pc2", idu_pc, INIT + 32'h8);

        // 2: stall 3 cycles on slot 0x...08
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'd0, idu_valid}, 32'd1);
            check("stall_pc", idu_pc, INIT + 32'h8);
            check("stall_inst", idu_inst, 32'd2);
            check("stall_addr", rom_rd_addr, INIT + 32'hC);
        end
        ready = 1'b1;
        tick();
        check("release_pc", idu_pc, INIT + 32'hC);

        // 3: redirect while stalled; slot 0x...0C is flushed
        ready  = 1'b0;
        jmp_en = 1'b1;
        jmp_pc = INIT + 32'h100;
        tick();
        check("jmp_flush", {31'd0, idu_valid}, 32'd0);
        check("jmp_addr", rom_rd_addr, INIT + 32'h100);
        jmp_en = 1'b0;
        ready  = 1'b1;
        push(INIT + 32'h100);
        push(INIT + 32'h104);
        tick();
        check("jmp_valid", {31'd0, idu_valid}, 32'd1);
        check("jmp_pc", idu_pc, INIT + 32'h100);
        tick();

        // 5: halt beats jump; slot 0x...104 retained until ready
        ready  = 1'b0;
        halt   = 1'b1;
        jmp_en = 1'b1;
        jmp_pc = INIT + 32'h200;
        tick();
        halt   = 1'b0;
        jmp_en = 1'b0;
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_rom_en", {31'd0, rom_rd_en}, 32'd0);
        check("halt_addr", rom_rd_addr, INIT + 32'h108);
        tick();
        check("halt_keep_valid", {31'd0, idu_valid}, 32'd1);
        check("halt_keep_pc", idu_pc, INIT + 32'h104);
        check("halt_misalign", {31'd0, excp_misalign}, 32'd0);
        ready = 1'b1;
        tick();
        check("halt_drained", {31'd0, idu_valid}, 32'd0);
        tick();
        check("halt_stays", {31'd0, halted}, 32'd1);

        // 6: asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("areset_halted", {31'd0, halted}, 32'd0);
        tick();
        rst_n = 1'b1;
        push(INIT);
        push(INIT + 32'h4);
        tick();
        tick();
        tick();
        tick();
        check("pre_areset_pc", idu_pc, INIT + 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'd0, idu_valid}, 32'd0);
        check("areset_pc", idu_pc, INIT);
        check("areset_inst", idu_inst, 32'd0);
        check("areset_rom_en", {31'd0, rom_rd_en}, 32'd0);
        check("areset_addr", rom_rd_addr, INIT);
        tick();
        rst_n = 1'b1;
        check("post_idle_rom_en", {31'd0, rom_rd_en}, 32'd0);
        push(INIT);

        // 4: misaligned redirect traps and halts
        tick();
        check("post_addr", rom_rd_addr, INIT);
        tick();
        check("post_pc0", idu_pc, INIT);
        tick();
        ready  = 1'b0;
        jmp_en = 1'b1;
        jmp_pc = INIT + 32'h102;
        tick();
        check("mis_flag", {31'd0, excp_misalign}, 32'd1);
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_rom_en", {31'd0, rom_rd_en}, 32'd0);
        check("mis_valid", {31'd0, idu_valid}, 32'd0);
        check("mis_addr", rom_rd_addr, INIT + 32'h8);
        jmp_pc = INIT + 32'h100;
        tick();
        tick();
        check("mis_ignore_jmp", rom_rd_addr, INIT + 32'h8);
        check("mis_sticky", {31'd0, excp_misalign}, 32'd1);
        jmp_en = 1'b0;

        check("sb_left", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ifu

`default_nettype wire
